// File: rtl/gate_response_checker_pkg.sv
// Shared types and truth-table constants for the gate response checker
// and the benches that drive it.
package gate_response_checker_pkg;

  // Checker FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_HOLD   = 2'b10
  } state_e;

  // Operations the FSM can request from the settle counter.
  typedef enum logic [1:0] {
    CNT_KEEP  = 2'b00,
    CNT_ZERO  = 2'b01,
    CNT_LOAD1 = 2'b10,
    CNT_INC   = 2'b11
  } cnt_op_e;

  // Settle counter width; covers the full 1..255 settle range.
  localparam int CNT_W = 8;

  // Expected-output tables, bit index = {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  // One-hot coverage bit for a stimulus vector.
  function automatic logic [3:0] vec_onehot(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

endpackage

// File: rtl/gate_response_checker_settle_counter.sv
// Counts consecutive stable stimulus edges. The FSM chooses the operation;
// o_reached reports that the value being written this edge meets the
// settle threshold, so the sample can happen on that same edge.
module gate_response_checker_settle_counter
  import gate_response_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  cnt_op_e i_op,
  output logic    o_reached
);

  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // Next count: zero, restart at one, saturating increment, or hold.
  always_comb begin
    w_count_nxt = r_count;
    case (i_op)
      CNT_ZERO:  w_count_nxt = {CNT_W{1'b0}};
      CNT_LOAD1: w_count_nxt = CNT_W'(1);
      CNT_INC: begin
        if (r_count == {CNT_W{1'b1}}) begin
          w_count_nxt = r_count;
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      CNT_KEEP:  w_count_nxt = r_count;
      default:   w_count_nxt = {CNT_W{1'b0}};
    endcase
  end

  // >= rather than == so a run restarted by clear still samples when the
  // threshold is a single edge.
  assign o_reached = (w_count_nxt >= SETTLE_LIM);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/gate_response_checker.sv
// Gate response checker: waits for each {a,b} vector to settle, samples
// dut_out once against a programmable truth table, and accumulates a
// saturating mismatch count plus sticky input-vector coverage.
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [3:0]       truth_table,
  input  logic             a,
  input  logic             b,
  input  logic             dut_out,
  output logic             sample_valid,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       seen,
  output logic             done
);

  logic [1:0]       w_vec;
  logic [1:0]       r_vec_prev;
  logic             w_change;
  logic             w_expected;
  logic             w_mis;
  state_e           r_state;
  state_e           w_state_nxt;
  cnt_op_e          w_cnt_op;
  logic             w_reached;
  logic             w_sample;
  logic             r_sample_valid;
  logic             r_mismatch;
  logic [ERR_W-1:0] r_err_count;
  logic [3:0]       r_seen;
  logic [3:0]       w_seen_nxt;
  logic             r_done;

  assign w_vec      = {a, b};
  assign w_change   = (w_vec != r_vec_prev);
  assign w_expected = truth_table[w_vec];
  assign w_mis      = (dut_out != w_expected);
  assign w_seen_nxt = r_seen | vec_onehot(w_vec);

  gate_response_checker_settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_op      (w_cnt_op),
    .o_reached (w_reached)
  );

  // Previous-vector register used for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_prev <= 2'b00;
    end else begin
      r_vec_prev <= w_vec;
    end
  end

  // Next state, counter operation and sample decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_op    = CNT_KEEP;
    w_sample    = 1'b0;
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_op    = CNT_ZERO;
    end else if (clear) begin
      // Clear wins over a coincident sample and restarts settling.
      w_state_nxt = ST_SETTLE;
      w_cnt_op    = CNT_LOAD1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The enabling edge is the first observation of the vector.
          w_cnt_op    = CNT_LOAD1;
          w_sample    = w_reached;
          w_state_nxt = w_reached ? ST_HOLD : ST_SETTLE;
        end
        ST_SETTLE: begin
          w_cnt_op    = w_change ? CNT_LOAD1 : CNT_INC;
          w_sample    = w_reached;
          w_state_nxt = w_reached ? ST_HOLD : ST_SETTLE;
        end
        ST_HOLD: begin
          if (w_change) begin
            w_cnt_op    = CNT_LOAD1;
            w_sample    = w_reached;
            w_state_nxt = w_reached ? ST_HOLD : ST_SETTLE;
          end else begin
            w_cnt_op    = CNT_KEEP;
            w_state_nxt = ST_HOLD;
          end
        end
        default: begin
          w_cnt_op    = CNT_ZERO;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result pulses, saturating error count and sticky coverage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_valid <= 1'b0;
      r_mismatch     <= 1'b0;
      r_err_count    <= {ERR_W{1'b0}};
      r_seen         <= 4'b0000;
      r_done         <= 1'b0;
    end else if (clear) begin
      r_sample_valid <= 1'b0;
      r_mismatch     <= 1'b0;
      r_err_count    <= {ERR_W{1'b0}};
      r_seen         <= 4'b0000;
      r_done         <= 1'b0;
    end else if (w_sample) begin
      r_sample_valid <= 1'b1;
      r_mismatch     <= w_mis;
      if (w_mis && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end else begin
        r_err_count <= r_err_count;
      end
      r_seen <= w_seen_nxt;
      r_done <= &w_seen_nxt;
    end else begin
      r_sample_valid <= 1'b0;
      r_mismatch     <= 1'b0;
    end
  end

  assign sample_valid = r_sample_valid;
  assign mismatch     = r_mismatch;
  assign err_count    = r_err_count;
  assign seen         = r_seen;
  assign done         = r_done;

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Hardware response checker for the two-input gate lab blocks. It watches the same a/b stimulus that drives a gate DUT, together with the DUT output. It waits until each stimulus vector has been stable for a settle window, then samples the output once and compares it against a programmable 4-entry truth table. It accumulates a mismatch count and input-vector coverage, so a bench or board can report pass/fail without waveform inspection.

Parameters:
SETTLE_CYCLES, 4, consecutive rising edges {a,b} must hold before the output is sampled; legal range 1..255.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  checking enable; 0 = idle, counters hold.
clear  input  1  synchronous clear of err_count, seen and done.
truth_table  input  4  expected output; bit index = {a,b} (bit3 = a1b1).
a  input  1  DUT stimulus a, synchronous to clk.
b  input  1  DUT stimulus b, synchronous to clk.
dut_out  input  1  DUT response, synchronous to clk.
sample_valid  output  1  one-cycle pulse: a comparison happened.
mismatch  output  1  one-cycle pulse, coincident with sample_valid, when dut_out != expected.
err_count  output  ERR_W  saturating mismatch count.
seen  output  4  sticky coverage; bit {a,b} set once that vector has been sampled.
done  output  1  sticky; high when seen == 4'b1111.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0.
  - FSM to IDLE; settle counter 0; vec_prev 2'b00.
  - Release is synchronous to the next clk edge.
- vec = {a,b}, sampled every edge. vec_prev is the registered previous vec. change = (vec != vec_prev).
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE:
    - Counter 0.
    - en=1 -> SETTLE with counter = 1 (the current edge counts as the first observation).
  - SETTLE:
    - change=1 -> counter = 1.
    - Otherwise counter increments.
    - When the counter would reach SETTLE_CYCLES on an edge with change=0 (or SETTLE_CYCLES=1 at entry), sample on that edge:
      - expected = truth_table[vec].
      - sample_valid=1 next cycle.
      - mismatch = (dut_out != expected).
      - seen[vec] set.
      - err_count increments on mismatch, saturating at all-ones.
      - Go to HOLD.
  - HOLD:
    - No further sampling of the same stable vector.
    - change=1 -> SETTLE, counter = 1.
- Latency: with vector change first seen on edge k, sampling occurs on edge k+SETTLE_CYCLES-1. Outputs are registered and visible after that edge.
- en=0 in any state:
  - Next state IDLE; no sample.
  - err_count, seen and done retained.
  - Re-enabling restarts settling, even if {a,b} is unchanged.
- clear=1:
  - err_count, seen, done go to 0 and sample_valid/mismatch are suppressed on that edge.
  - FSM goes to SETTLE (counter = 1) if en=1, else IDLE.
  - clear has priority over a coincident sample.
- dut_out changing during SETTLE does not restart settling; only stimulus changes do.
- done = &seen, registered alongside seen. It is asserted the cycle after the fourth distinct vector is sampled.
- truth_table is read only at the sample edge; it may change between samples.
- Mismatch while err_count is saturated: the mismatch pulse still fires and the count stays at max.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, SETTLE, HOLD).
  - Truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, for both benches and tops.
- One natural sub-module, settle_counter: counts stable edges, restarts on change, and outputs a reached pulse. The FSM, compare and accounting stay in the top.

Test Plan:
- AND check, clean:
  - Stimulus: truth_table=TT_AND, en=1; apply 00,01,10,11 each held 10 cycles, dut_out = a&b.
  - Required: exactly 4 sample_valid pulses, each 3 edges after the change; mismatch never high; err_count=0; seen=1111; done=1 after the 4th sample.
- Wrong response:
  - Stimulus: as above but dut_out=1 for vector 01.
  - Required: one mismatch pulse coincident with the 2nd sample_valid; err_count=1; done=1.
- Glitch rejection:
  - Stimulus: hold 10 for 2 cycles, then 11 for 10 cycles.
  - Required: no sample for 10; seen=1000; a single sample_valid for 11.
- Saturation:
  - Stimulus: ERR_W=2; 5 mismatching stable vectors.
  - Required: err_count sequence 1,2,3,3,3; 5 mismatch pulses.
- Clear and enable interplay:
  - Stimulus: assert clear on the exact sample edge.
  - Required: no sample_valid; err_count=0; seen=0000; resample after 4 more stable edges.
  - Stimulus: en=0 mid-SETTLE.
  - Required: no sample; counts retained.
- Asynchronous reset mid-SETTLE:
  - Stimulus: rst_n low between edges with err_count=2.
  - Required: all outputs 0 immediately, without a clock edge; after release, the first sample occurs SETTLE_CYCLES edges later.
